// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// FSM encoding and EX forwarding mux select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush perf counters.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up on inc until all ones, clear on reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage pipeline: load-use stall,
// redirect flush, dmem wait freeze, forwarding selects, perf counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_waddr,
  input  logic                  mem_redirect,
  input  logic                  dmem_busy,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [1:0]            state
);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  state_e     eff;
  logic [2:0] cnt_q, cnt_d;
  logic       hazard;
  logic       st_inc;
  logic       fl_inc;

  assign hazard = ex_mem_read && (ex_waddr != '0) &&
                  ((ex_waddr == id_rs) ||
                   (id_uses_rt && (ex_waddr == id_rt)));

  // Resolve the state to act on; a finished wait resumes its saved state.
  always_comb begin
    eff = (state_q == ST_WAIT) ? ret_q : state_q;
    if (eff != ST_LOAD) eff = ST_RUN;
  end

  // Prioritised stage control and next-state selection.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    cnt_d        = cnt_q;
    st_inc       = 1'b0;
    fl_inc       = 1'b0;
    if (srst || !enable) begin
      st_inc = 1'b0;
    end else if (dmem_busy) begin
      state_d = ST_WAIT;
      ret_d   = eff;
      st_inc  = 1'b1;
    end else if (mem_redirect) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
      {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
      state_d = ST_RUN;
      cnt_d   = '0;
      fl_inc  = 1'b1;
    end else if (eff == ST_LOAD) begin
      {id_ex_en, ex_mem_en, mem_wb_en} = '1;
      id_ex_flush = 1'b1;
      st_inc      = 1'b1;
      cnt_d       = cnt_q - 3'd1;
      state_d     = (cnt_q <= 3'd1) ? ST_RUN : ST_LOAD;
    end else if (hazard) begin
      {id_ex_en, ex_mem_en, mem_wb_en} = '1;
      id_ex_flush = 1'b1;
      st_inc      = 1'b1;
      if (LOAD_STALL_CYC > 1) begin
        state_d = ST_LOAD;
        cnt_d   = 3'(LOAD_STALL_CYC - 1);
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
      state_d = ST_RUN;
    end
  end

  // FSM, saved pre-wait state and bubble counter.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      cnt_q   <= '0;
    end else if (enable) begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX operand forwarding, MEM result preferred over WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!srst) begin
      if (mem_reg_write && (mem_waddr != '0) && (mem_waddr == ex_rs))
        fwd_a = FWD_MEM;
      else if (wb_reg_write && (wb_waddr != '0) && (wb_waddr == ex_rs))
        fwd_a = FWD_WB;
      if (mem_reg_write && (mem_waddr != '0) && (mem_waddr == ex_rt))
        fwd_b = FWD_MEM;
      else if (wb_reg_write && (wb_waddr != '0) && (wb_waddr == ex_rt))
        fwd_b = FWD_WB;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .srst  (srst),
    .inc   (st_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .srst  (srst),
    .inc   (fl_inc),
    .count (flush_cnt)
  );

  assign state = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three parameterisations driven in lockstep
// against a behavioural model of bubbles, waits and counters.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       srst, enable;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_waddr, mem_waddr, wb_waddr;
  logic       id_uses_rt, ex_mem_read, mem_reg_write, wb_reg_write;
  logic       mem_redirect, dmem_busy;

  logic [11:0] o_ctl[3];
  logic [1:0]  o_st[3];
  int          o_sc[3];
  int          o_fc[3];

  int P_CYC[3] = '{3, 1, 2};
  int P_MAX[3] = '{65535, 65535, 3};

  int m_rem[3];
  bit m_wait[3];
  int m_sc[3];
  int m_fc[3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CYC = (g == 0) ? 3 : ((g == 1) ? 1 : 2);
    localparam int CW  = (g == 2) ? 2 : 16;
    logic [CW-1:0] sc, fc;
    logic [1:0]    st, fa, fb;
    logic          pe, ie, de, xe, me, ifl, dfl, xfl;
    hazard_unit #(
      .REG_ADDR_W(5), .LOAD_STALL_CYC(CYC), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .srst(srst), .enable(enable),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
      .ex_waddr(ex_waddr), .mem_reg_write(mem_reg_write),
      .mem_waddr(mem_waddr), .wb_reg_write(wb_reg_write),
      .wb_waddr(wb_waddr), .mem_redirect(mem_redirect),
      .dmem_busy(dmem_busy),
      .pc_en(pe), .if_id_en(ie), .id_ex_en(de),
      .ex_mem_en(xe), .mem_wb_en(me),
      .if_id_flush(ifl), .id_ex_flush(dfl), .ex_mem_flush(xfl),
      .fwd_a(fa), .fwd_b(fb),
      .stall_cnt(sc), .flush_cnt(fc), .state(st)
    );
    assign o_ctl[g] = {pe, ie, de, xe, me, ifl, dfl, xfl, fa, fb};
    assign o_st[g]  = st;
    assign o_sc[g]  = 32'(sc);
    assign o_fc[g]  = 32'(fc);
  end

  function automatic bit m_hazard();
    return ex_mem_read && ex_waddr != 0 &&
           (ex_waddr == id_rs || (id_uses_rt && ex_waddr == id_rt));
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] src);
    if (srst) return 2'b00;
    if (mem_reg_write && mem_waddr != 0 && mem_waddr == src) return 2'b10;
    if (wb_reg_write && wb_waddr != 0 && wb_waddr == src) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {5 enables, 3 flushes, fwd_a, fwd_b} for this cycle.
  function automatic logic [11:0] exp_ctl(int i);
    logic [7:0] e;
    if (srst) return 12'h000;
    if (!enable || dmem_busy) e = 8'b00000_000;
    else if (mem_redirect) e = 8'b11111_111;
    else if (m_rem[i] > 0 || m_hazard()) e = 8'b00111_010;
    else e = 8'b11111_000;
    return {e, m_fwd(ex_rs), m_fwd(ex_rt)};
  endfunction

  function automatic logic [1:0] exp_st(int i);
    if (m_wait[i]) return 2'd2;
    return (m_rem[i] > 0) ? 2'd1 : 2'd0;
  endfunction

  function automatic int sat_inc(int v, int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  // Advance the model across one clock edge.
  task automatic model_step(int i);
    if (srst) begin
      m_rem[i] = 0; m_wait[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end else if (!enable) begin
      m_rem[i] = m_rem[i];
    end else if (dmem_busy) begin
      m_wait[i] = 1;
      m_sc[i] = sat_inc(m_sc[i], P_MAX[i]);
    end else if (mem_redirect) begin
      m_wait[i] = 0; m_rem[i] = 0;
      m_fc[i] = sat_inc(m_fc[i], P_MAX[i]);
    end else if (m_rem[i] > 0) begin
      m_wait[i] = 0; m_rem[i]--;
      m_sc[i] = sat_inc(m_sc[i], P_MAX[i]);
    end else if (m_hazard()) begin
      m_wait[i] = 0; m_rem[i] = P_CYC[i] - 1;
      m_sc[i] = sat_inc(m_sc[i], P_MAX[i]);
    end else begin
      m_wait[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
  endtask

  task automatic idle();
    srst = 0; enable = 1;
    id_rs = 0; id_rt = 0; id_uses_rt = 1;
    ex_rs = 0; ex_rt = 0; ex_mem_read = 0; ex_waddr = 0;
    mem_reg_write = 0; mem_waddr = 0;
    wb_reg_write = 0; wb_waddr = 0;
    mem_redirect = 0; dmem_busy = 0;
  endtask

  task automatic load8();
    ex_mem_read = 1; ex_waddr = 8; id_rs = 8;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c < 2) begin
        srst = 1; load8(); mem_redirect = 1;
        mem_reg_write = 1; mem_waddr = 3; ex_rs = 3;
      end
      #2;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if ({o_ctl[i], o_st[i], o_sc[i], o_fc[i]} !==
            {exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]}) begin
          n_fail++;
          $display("FAIL reset c%0d inst%0d got ctl=%b st=%0d sc=%0d fc=%0d want ctl=%b st=%0d sc=%0d fc=%0d",
            c, i, o_ctl[i], o_st[i], o_sc[i], o_fc[i],
            exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 12; c++) begin
      idle();
      case (c)
        0: load8();
        5: begin ex_mem_read = 1; ex_waddr = 0; id_rs = 0; end
        6: begin
          ex_mem_read = 1; ex_waddr = 9; id_rt = 9;
          id_rs = 1; id_uses_rt = 0;
        end
        7: begin ex_mem_read = 1; ex_waddr = 9; id_rt = 9; id_rs = 1; end
        default: ;
      endcase
      #2;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if ({o_ctl[i], o_st[i], o_sc[i], o_fc[i]} !==
            {exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]}) begin
          n_fail++;
          $display("FAIL load_use c%0d inst%0d got ctl=%b st=%0d sc=%0d fc=%0d want ctl=%b st=%0d sc=%0d fc=%0d",
            c, i, o_ctl[i], o_st[i], o_sc[i], o_fc[i],
            exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_forwarding();
    for (int c = 0; c < 5; c++) begin
      idle();
      ex_rs = 5; ex_rt = 5; mem_waddr = 5; wb_waddr = 5;
      mem_reg_write = 1; wb_reg_write = 1;
      case (c)
        1: mem_reg_write = 0;
        2: begin mem_waddr = 0; wb_waddr = 0; ex_rs = 0; ex_rt = 0; end
        3: begin ex_rt = 6; wb_waddr = 6; end
        4: begin mem_reg_write = 0; wb_reg_write = 0; end
        default: ;
      endcase
      #2;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if ({o_ctl[i], o_st[i], o_sc[i], o_fc[i]} !==
            {exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]}) begin
          n_fail++;
          $display("FAIL forwarding c%0d inst%0d got ctl=%b st=%0d sc=%0d fc=%0d want ctl=%b st=%0d sc=%0d fc=%0d",
            c, i, o_ctl[i], o_st[i], o_sc[i], o_fc[i],
            exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    for (int c = 0; c < 7; c++) begin
      idle();
      case (c)
        0: load8();
        1: mem_redirect = 1;
        3: begin load8(); mem_redirect = 1; end
        default: ;
      endcase
      #2;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if ({o_ctl[i], o_st[i], o_sc[i], o_fc[i]} !==
            {exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]}) begin
          n_fail++;
          $display("FAIL redirect c%0d inst%0d got ctl=%b st=%0d sc=%0d fc=%0d want ctl=%b st=%0d sc=%0d fc=%0d",
            c, i, o_ctl[i], o_st[i], o_sc[i], o_fc[i],
            exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_dmem_wait();
    for (int c = 0; c < 12; c++) begin
      idle();
      case (c)
        0: load8();
        1, 2, 3, 4: begin dmem_busy = 1; mem_redirect = 1; end
        5: mem_redirect = 1;
        7: begin load8(); enable = 0; end
        8: begin load8(); enable = 0; dmem_busy = 1; end
        9: begin dmem_busy = 1; end
        default: ;
      endcase
      #2;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if ({o_ctl[i], o_st[i], o_sc[i], o_fc[i]} !==
            {exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]}) begin
          n_fail++;
          $display("FAIL dmem_wait c%0d inst%0d got ctl=%b st=%0d sc=%0d fc=%0d want ctl=%b st=%0d sc=%0d fc=%0d",
            c, i, o_ctl[i], o_st[i], o_sc[i], o_fc[i],
            exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 14; c++) begin
      idle();
      if (c == 0) srst = 1;
      else if (c < 10) load8();
      else if (c == 11) srst = 1;
      if (c == 10) load8();
      #2;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if ({o_ctl[i], o_st[i], o_sc[i], o_fc[i]} !==
            {exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]}) begin
          n_fail++;
          $display("FAIL back_to_back c%0d inst%0d got ctl=%b st=%0d sc=%0d fc=%0d want ctl=%b st=%0d sc=%0d fc=%0d",
            c, i, o_ctl[i], o_st[i], o_sc[i], o_fc[i],
            exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      srst          = ($urandom_range(0, 49) == 0);
      enable        = ($urandom_range(0, 9) != 0);
      dmem_busy     = ($urandom_range(0, 7) == 0);
      mem_redirect  = ($urandom_range(0, 7) == 0);
      ex_mem_read   = 1'($urandom_range(0, 1));
      id_uses_rt    = 1'($urandom_range(0, 1));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write  = 1'($urandom_range(0, 1));
      id_rs     = 5'($urandom_range(0, 3));
      id_rt     = 5'($urandom_range(0, 3));
      ex_rs     = 5'($urandom_range(0, 3));
      ex_rt     = 5'($urandom_range(0, 3));
      ex_waddr  = 5'($urandom_range(0, 3));
      mem_waddr = 5'($urandom_range(0, 3));
      wb_waddr  = 5'($urandom_range(0, 3));
      #2;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if ({o_ctl[i], o_st[i], o_sc[i], o_fc[i]} !==
            {exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]}) begin
          n_fail++;
          $display("FAIL random c%0d inst%0d got ctl=%b st=%0d sc=%0d fc=%0d want ctl=%b st=%0d sc=%0d fc=%0d",
            c, i, o_ctl[i], o_st[i], o_sc[i], o_fc[i],
            exp_ctl(i), exp_st(i), m_sc[i], m_fc[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    idle();
    srst = 1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_forwarding();
    test_redirect();
    test_dmem_wait();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
